cpu_ctrl_fsm: RTL and testbench

Multi-cycle control unit for the 8-bit accumulator CPU. It sits directly downstream of the instruction register and consumes `ir_cu`. It drives the PC mode, the ALU opcode and the write strobes for the accumulator, data memory and IR. It replaces ad-hoc single-cycle decode with a four-state fetch/decode/execute/writeback sequencer that adds a HALT state and a retired-instruction counter.

---
 rtl/cpu_ctrl_fsm.sv | 195 +++++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_fsm
//   Multi-cycle control unit for the 8-bit accumulator CPU. Every instruction
//   passes through FETCH -> DECODE -> EXEC -> WB (4 cycles). A HALT opcode
//   parks the sequencer in HALT until reset. A retired-instruction counter
//   advances on every WB exit, HALT included.
//
//   Optional feature macro: CPU_CTRL_ILLEGAL_TRAP_EN
//     defined   : opcodes B..F hold the PC in WB, then trap into HALT with
//                 illegal=1 (held until reset)
//     undefined : opcodes B..F execute as NOP, illegal stays 0
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-low reset
//   ir_cu      in   [7:0] instruction, opcode = ir_cu[7:4]
//   acc_zero   in   accumulator==0 flag, used by JZ in WB
//   pc_mode    out  [2:0] 0 HOLD, 1 INC, 2 JUMP, 4 CLEAR
//   cu_alu     out  [3:0] 0 PASS_B, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 NOT_A, F IDLE
//   ir_load    out  IR load strobe (FETCH)
//   wacc       out  accumulator write strobe (WB)
//   wm         out  data-memory write strobe (WB)
//   halted     out  sequencer is in HALT
//   illegal    out  illegal-opcode trap flag
//   instr_cnt  out  [CNT_W-1:0] retired-instruction count
//   state      out  [2:0] 0 FETCH, 1 DECODE, 2 EXEC, 3 WB, 4 HALT
// -----------------------------------------------------------------------------
module cpu_ctrl_fsm #(
  parameter int unsigned CNT_W    = 8,
  parameter logic [3:0]  HALT_OPC = 4'hA
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       ir_cu,
  input  logic             acc_zero,
  output logic [2:0]       pc_mode,
  output logic [3:0]       cu_alu,
  output logic             ir_load,
  output logic             wacc,
  output logic             wm,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [2:0]       state
);

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  localparam logic [2:0] PC_HOLD  = 3'd0;
  localparam logic [2:0] PC_INC   = 3'd1;
  localparam logic [2:0] PC_JUMP  = 3'd2;
  localparam logic [2:0] PC_CLEAR = 3'd4;

  localparam logic [3:0] ALU_IDLE = 4'hF;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;

  // ALU operation requested by an opcode during EXEC/WB.
  function automatic logic [3:0] alu_of(input logic [3:0] op);
    case (op)
      4'h1:    alu_of = 4'h0;  // LDA -> PASS_B
      4'h3:    alu_of = 4'h1;  // ADD
      4'h4:    alu_of = 4'h2;  // SUB
      4'h5:    alu_of = 4'h3;  // AND
      4'h6:    alu_of = 4'h4;  // OR
      4'h7:    alu_of = 4'h5;  // NOT -> NOT_A
      default: alu_of = ALU_IDLE;
    endcase
  endfunction

  // Opcodes whose result is written back into the accumulator.
  function automatic logic writes_acc(input logic [3:0] op);
    case (op)
      4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: writes_acc = 1'b1;
      default:                            writes_acc = 1'b0;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;

  logic             op_illegal_s;
  logic             trap_s;
  logic             unused_operand_s;

  // Operand bits are consumed by the datapath, not by the sequencer.
  assign unused_operand_s = ^ir_cu[3:0];
  assign op_illegal_s     = (op_q > 4'hA);
  assign trap_s           = TRAP_EN & op_illegal_s;

  // Next-state, latched opcode, counter and sticky flags.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    instr_cnt_d = instr_cnt_q;
    halted_d    = halted_q;
    illegal_d   = illegal_q;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        op_d    = ir_cu[7:4];
        state_d = ST_EXEC;
      end
      ST_EXEC:   state_d = ST_WB;
      ST_WB: begin
        instr_cnt_d = instr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if ((op_q == HALT_OPC) || trap_s) begin
          state_d   = ST_HALT;
          halted_d  = 1'b1;
          illegal_d = trap_s;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Sequencer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_FETCH;
      op_q        <= OP_NOP;
      instr_cnt_q <= {CNT_W{1'b0}};
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      instr_cnt_q <= instr_cnt_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
    end
  end

  // Moore output decode; reset forces safe values combinationally.
  always_comb begin
    pc_mode = PC_HOLD;
    cu_alu  = ALU_IDLE;
    ir_load = 1'b0;
    wacc    = 1'b0;
    wm      = 1'b0;
    if (!reset) begin
      pc_mode = PC_CLEAR;
    end else begin
      case (state_q)
        ST_FETCH:  ir_load = 1'b1;
        ST_DECODE: pc_mode = PC_HOLD;
        ST_EXEC:   cu_alu  = alu_of(op_q);
        ST_WB: begin
          cu_alu = alu_of(op_q);
          wacc   = writes_acc(op_q);
          wm     = (op_q == OP_STA);
          // JZ is the only output that looks at a live input.
          if (op_q == OP_JMP) begin
            pc_mode = PC_JUMP;
          end else if (op_q == OP_JZ) begin
            pc_mode = acc_zero ? PC_JUMP : PC_INC;
          end else if ((op_q == HALT_OPC) || trap_s) begin
            pc_mode = PC_HOLD;
          end else begin
            pc_mode = PC_INC;
          end
        end
        ST_HALT:   pc_mode = PC_HOLD;
        default:   pc_mode = PC_HOLD;
      endcase
    end
  end

  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign instr_cnt = instr_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
module tb_cpu_ctrl_fsm;

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ir_cu;
  logic       acc_zero;
  logic [2:0] pc_mode;
  logic [3:0] cu_alu;
  logic       ir_load, wacc, wm, halted, illegal;
  logic [7:0] instr_cnt;
  logic [2:0] state;

  always #5 clk = ~clk;

  cpu_ctrl_fsm dut (
    .clk(clk), .reset(reset), .ir_cu(ir_cu), .acc_zero(acc_zero),
    .pc_mode(pc_mode), .cu_alu(cu_alu), .ir_load(ir_load), .wacc(wacc),
    .wm(wm), .halted(halted), .illegal(illegal), .instr_cnt(instr_cnt),
    .state(state)
  );

  typedef struct {
    logic       rst;
    logic [7:0] ir;
    logic       az;
    logic [2:0] pc;
    logic [3:0] alu;
    logic       irl, wa, wmm, hlt;
    logic [2:0] st;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[30];
  int   n_vec = 0;
  int   n_bad = 0;

  // Instruction-level reference: cycle within the instruction, opcode,
  // retired count and halt/trap flags.
  int         m_phase;
  logic [3:0] m_op;
  int         m_cnt;
  bit         m_halt, m_ill;
  logic [3:0] alu_tab[16];

  function automatic logic [22:0] pack(input logic [2:0] pc, input logic [3:0] alu,
                                       input logic irl, input logic wa, input logic wmm,
                                       input logic hlt, input logic ill,
                                       input logic [2:0] st, input logic [7:0] cnt);
    pack = {pc, alu, irl, wa, wmm, hlt, ill, st, cnt};
  endfunction

  function automatic logic [22:0] model_exp(input logic r, input logic az);
    logic [2:0] pc;
    logic [3:0] alu;
    logic       irl, wa, wmm;
    logic [2:0] st;
    pc = 3'd0; alu = 4'hF; irl = 1'b0; wa = 1'b0; wmm = 1'b0;
    if (!r) begin
      pc = 3'd4;
    end else if (m_halt) begin
      pc = 3'd0;
    end else if (m_phase == 0) begin
      irl = 1'b1;
    end else if (m_phase >= 2) begin
      alu = alu_tab[m_op];
      if (m_phase == 3) begin
        wa  = (m_op >= 4'd1) && (m_op <= 4'd7) && (m_op != 4'd2);
        wmm = (m_op == 4'd2);
        if (m_op == 4'd8 || (m_op == 4'd9 && az)) pc = 3'd2;
        else if (m_op == 4'hA || (TRAP && m_op > 4'hA)) pc = 3'd0;
        else pc = 3'd1;
      end
    end
    st = m_halt ? 3'd4 : 3'(m_phase);
    model_exp = pack(pc, alu, irl, wa, wmm, m_halt, m_ill, st, 8'(m_cnt));
  endfunction

  task automatic model_edge(input logic r, input logic [7:0] ir);
    if (!r) begin
      m_phase = 0; m_op = 4'h0; m_cnt = 0; m_halt = 1'b0; m_ill = 1'b0;
    end else if (!m_halt) begin
      if (m_phase == 1) m_op = ir[7:4];
      if (m_phase == 3) begin
        m_cnt = (m_cnt + 1) % 256;
        if (m_op == 4'hA || (TRAP && m_op > 4'hA)) begin
          m_halt = 1'b1;
          m_ill  = (m_op > 4'hA);
        end
      end
      m_phase = (m_phase + 1) % 4;
    end
  endtask

  task automatic check(input string name, input logic [22:0] exp);
    logic [22:0] act;
    act = {pc_mode, cu_alu, ir_load, wacc, wm, halted, illegal, state, instr_cnt};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got pc=%0d alu=%0h irl=%0b wacc=%0b wm=%0b hlt=%0b ill=%0b st=%0d cnt=%0d, want pc=%0d alu=%0h irl=%0b wacc=%0b wm=%0b hlt=%0b ill=%0b st=%0d cnt=%0d",
               name, act[22:20], act[19:16], act[15], act[14], act[13], act[12], act[11], act[10:8], act[7:0],
               exp[22:20], exp[19:16], exp[15], exp[14], exp[13], exp[12], exp[11], exp[10:8], exp[7:0]);
    end
  endtask

  // One clock: drive, settle, compare against the model, advance.
  task automatic cycle(input logic r, input logic [7:0] ir, input logic az, input string name);
    reset = r; ir_cu = ir; acc_zero = az;
    #1;
    check(name, model_exp(r, az));
    @(posedge clk);
    model_edge(r, ir);
    #1;
  endtask

  task automatic instr(input logic [7:0] ir, input logic az, input string name);
    for (int k = 0; k < 4; k++) cycle(1'b1, ir, az, name);
  endtask

  initial begin
    alu_tab = '{4'hF, 4'h0, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    //          rst   ir     az    pc    alu   irl   wa    wm    hlt   st    cnt
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 3'd4, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 3'd4, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0};
    vecs[2]  = '{1'b1, 8'h35, 1'b0, 3'd0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0};
    vecs[3]  = '{1'b1, 8'h35, 1'b0, 3'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'd0};
    vecs[4]  = '{1'b1, 8'h35, 1'b0, 3'd0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0};
    vecs[5]  = '{1'b1, 8'h35, 1'b0, 3'd1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 8'd0};
    vecs[6]  = '{1'b1, 8'h94, 1'b0, 3'd0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd1};
    vecs[7]  = '{1'b1, 8'h94, 1'b0, 3'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'd1};
    vecs[8]  = '{1'b1, 8'h94, 1'b0, 3'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'd1};
    vecs[9]  = '{1'b1, 8'h94, 1'b1, 3'd2, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 8'd1};
    vecs[10] = '{1'b1, 8'h27, 1'b0, 3'd0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd2};
    vecs[11] = '{1'b1, 8'h27, 1'b0, 3'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'd2};
    vecs[12] = '{1'b1, 8'h27, 1'b0, 3'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'd2};
    vecs[13] = '{1'b1, 8'h27, 1'b0, 3'd1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 8'd2};
    vecs[14] = '{1'b1, 8'h17, 1'b0, 3'd0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd3};
    vecs[15] = '{1'b1, 8'h17, 1'b0, 3'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'd3};
    vecs[16] = '{1'b1, 8'h17, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'd3};
    vecs[17] = '{1'b1, 8'h17, 1'b0, 3'd1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 8'd3};
    vecs[18] = '{1'b1, 8'hA0, 1'b0, 3'd0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd4};
    vecs[19] = '{1'b1, 8'hA0, 1'b0, 3'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'd4};
    vecs[20] = '{1'b1, 8'hA0, 1'b0, 3'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'd4};
    vecs[21] = '{1'b1, 8'hA0, 1'b0, 3'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 8'd4};
    vecs[22] = '{1'b1, 8'hA0, 1'b0, 3'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 8'd5};
    vecs[23] = '{1'b1, 8'h00, 1'b1, 3'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 8'd5};
    vecs[24] = '{1'b0, 8'h00, 1'b0, 3'd4, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 8'd5};
    vecs[25] = '{1'b1, 8'h8C, 1'b0, 3'd0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0};
    vecs[26] = '{1'b1, 8'h8C, 1'b0, 3'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'd0};
    vecs[27] = '{1'b1, 8'h8C, 1'b0, 3'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0};
    vecs[28] = '{1'b1, 8'h8C, 1'b0, 3'd2, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 8'd0};
    vecs[29] = '{1'b1, 8'h00, 1'b0, 3'd0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd1};

    // Bring the DUT out of its power-up unknown state.
    reset = 1'b0; ir_cu = 8'h00; acc_zero = 1'b0;
    @(posedge clk);
    model_edge(1'b0, 8'h00);
    #1;

    // Directed table: reset, ADD, JZ taken, STA, LDA, HALT, reset, JMP.
    for (int i = 0; i < 30; i++) begin
      reset = vecs[i].rst; ir_cu = vecs[i].ir; acc_zero = vecs[i].az;
      #1;
      check($sformatf("vec%0d", i),
            pack(vecs[i].pc, vecs[i].alu, vecs[i].irl, vecs[i].wa, vecs[i].wmm,
                 vecs[i].hlt, 1'b0, vecs[i].st, vecs[i].cnt));
      @(posedge clk);
      model_edge(vecs[i].rst, vecs[i].ir);
      #1;
    end

    // JZ not taken, JMP with acc_zero both ways.
    cycle(1'b0, 8'h00, 1'b0, "rst_jz");
    instr(8'h94, 1'b0, "jz_nt");
    instr(8'h8C, 1'b1, "jmp_az1");

    // HALT held for 10 cycles, counter frozen.
    instr(8'hA0, 1'b0, "halt");
    for (int k = 0; k < 10; k++) cycle(1'b1, 8'h35, 1'(k & 1), "halt_hold");
    n_vec++;
    if (instr_cnt !== 8'd3 || halted !== 1'b1) begin
      n_bad++;
      $display("FAIL halt_frozen: got cnt=%0d halted=%0b, want cnt=3 halted=1", instr_cnt, halted);
    end

    // Reset pulsed during EXEC of ADD: no write-back, restart at FETCH.
    cycle(1'b0, 8'h00, 1'b0, "rst_mid");
    cycle(1'b1, 8'h35, 1'b0, "mid_fetch");
    cycle(1'b1, 8'h35, 1'b0, "mid_decode");
    cycle(1'b0, 8'h35, 1'b0, "mid_exec_rst");
    cycle(1'b1, 8'h35, 1'b0, "mid_after");

    // Illegal opcode.
    cycle(1'b0, 8'h00, 1'b0, "rst_ill");
    instr(8'hF0, 1'b0, "illegal");
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'h00, 1'b0, "ill_after");

    // Counter wrap after 256 NOPs.
    cycle(1'b0, 8'h00, 1'b0, "rst_wrap");
    for (int k = 0; k < 256; k++) instr(8'h00, 1'b0, "nop_wrap");
    n_vec++;
    if (instr_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL cnt_wrap: got cnt=%0d, want 0", instr_cnt);
    end

    // Randomised instruction stream with occasional reset.
    cycle(1'b0, 8'h00, 1'b0, "rst_rand");
    for (int k = 0; k < 800; k++) begin
      cycle(($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1, 8'($urandom),
            1'($urandom), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
